// File: rtl/psc_trigger_receiver_if.sv
// PSC trigger link signal bundle: serial line in, decoded pulses and status out.
// The receiver takes the slave view; the line driver / status consumer takes the master view.
interface psc_trigger_receiver_if;
    logic       psc_input;
    logic       trigger_out;
    logic       pkt_valid;
    logic       crc_error;
    logic       framing_error;
    logic       locked;
    logic [7:0] cmd_byte;

    modport slave (
        input  psc_input,
        output trigger_out,
        output pkt_valid,
        output crc_error,
        output framing_error,
        output locked,
        output cmd_byte
    );

    modport master (
        output psc_input,
        input  trigger_out,
        input  pkt_valid,
        input  crc_error,
        input  framing_error,
        input  locked,
        input  cmd_byte
    );
endinterface

// File: rtl/psc_trigger_receiver.sv
// PSC trigger link receiver: bit recovery, 10-bit word / packet alignment, CRC-8 check, trigger pulse.
// Pulses appear one cycle after the CRC word's last bit is sampled; no backpressure, the serial line is free-running.
module psc_trigger_receiver #(
    parameter int         CLKS_PER_BIT = 5,
    parameter int         PKT_BYTES    = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [7:0] TRIG_CMD     = 8'h54,
    parameter int         LOS_BITS     = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    psc_trigger_receiver_if.slave bus
);

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    localparam int PW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LOS_LIMIT = LOS_BITS * CLKS_PER_BIT;
    localparam int LW        = $clog2(LOS_LIMIT + 1);
    localparam int IW        = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);
    localparam logic [LW-1:0] LOS_MAX   = LW'(LOS_LIMIT);
    localparam logic [IW-1:0] IDX_CMD   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PKT_BYTES - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd9;
    // Locking on SYNC skips byte 0's CRC step, so start from its contribution.
    localparam logic [7:0]    CRC_SEED  = crc8_byte(8'h00, SYNC_BYTE);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    logic          r_sync1, r_sync2, r_sync3;
    logic [PW-1:0] r_phase;
    logic [LW-1:0] r_los;
    state_t        r_state;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic [IW-1:0] r_byte_idx;
    logic [7:0]    r_crc;
    logic [7:0]    r_cmd_cand;
    logic [7:0]    r_cmd_byte;
    logic          r_trig, r_valid, r_crc_err, r_frm_err;

    logic          w_edge, w_sample, w_los;
    logic [9:0]    w_word;
    logic [7:0]    w_data;

    state_t        w_state_nxt;
    logic [8:0]    w_shift_nxt;
    logic [3:0]    w_bit_cnt_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [7:0]    w_crc_nxt;
    logic [7:0]    w_cand_nxt;
    logic [7:0]    w_cmd_nxt;
    logic          w_trig_nxt, w_valid_nxt, w_crc_err_nxt, w_frm_err_nxt;

    assign w_edge   = r_sync2 ^ r_sync3;
    assign w_sample = (r_phase == PH_SAMPLE);
    assign w_los    = (r_los == LOS_MAX);
    // The stored 9 bits plus the bit being sampled form the 10-bit word window.
    assign w_word   = {r_shift, r_sync3};
    assign w_data   = w_word[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_phase <= '0;
            r_los   <= '0;
        end else begin
            r_sync1 <= bus.psc_input;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_edge) begin
                r_phase <= '0;
            end else if (r_phase == PH_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
            // Saturates so a dead line reports loss once rather than wrapping.
            if (w_edge) begin
                r_los <= '0;
            end else if (!w_los) begin
                r_los <= r_los + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_HUNT;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_crc      <= '0;
            r_cmd_cand <= '0;
            r_cmd_byte <= '0;
            r_trig     <= 1'b0;
            r_valid    <= 1'b0;
            r_crc_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_idx <= w_idx_nxt;
            r_crc      <= w_crc_nxt;
            r_cmd_cand <= w_cand_nxt;
            r_cmd_byte <= w_cmd_nxt;
            r_trig     <= w_trig_nxt;
            r_valid    <= w_valid_nxt;
            r_crc_err  <= w_crc_err_nxt;
            r_frm_err  <= w_frm_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_idx_nxt     = r_byte_idx;
        w_crc_nxt     = r_crc;
        w_cand_nxt    = r_cmd_cand;
        w_cmd_nxt     = r_cmd_byte;
        w_trig_nxt    = 1'b0;
        w_valid_nxt   = 1'b0;
        w_crc_err_nxt = 1'b0;
        w_frm_err_nxt = 1'b0;

        if (w_sample) begin
            w_shift_nxt = w_word[8:0];
        end

        case (r_state)
            ST_HUNT: begin
                if (w_sample && (w_word == {2'b10, SYNC_BYTE})) begin
                    w_state_nxt   = ST_LOCKED;
                    w_idx_nxt     = IDX_CMD;
                    w_bit_cnt_nxt = '0;
                    w_crc_nxt     = CRC_SEED;
                end
            end
            ST_LOCKED: begin
                // Loss of signal wins so a coincident framing fault yields one pulse.
                if (w_los) begin
                    w_frm_err_nxt = 1'b1;
                    w_state_nxt   = ST_HUNT;
                end else if (w_sample) begin
                    if (r_bit_cnt != BIT_LAST) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else begin
                        w_bit_cnt_nxt = '0;
                        if ((w_word[9:8] != 2'b10) ||
                            ((r_byte_idx == '0) && (w_data != SYNC_BYTE))) begin
                            w_frm_err_nxt = 1'b1;
                            w_state_nxt   = ST_HUNT;
                        end else if (r_byte_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_crc_nxt = 8'h00;
                            if (w_data == r_crc) begin
                                w_valid_nxt = 1'b1;
                                w_cmd_nxt   = r_cmd_cand;
                                w_trig_nxt  = (r_cmd_cand == TRIG_CMD);
                            end else begin
                                w_crc_err_nxt = 1'b1;
                            end
                        end else begin
                            w_crc_nxt = crc8_byte(r_crc, w_data);
                            w_idx_nxt = r_byte_idx + IW'(1);
                            if (r_byte_idx == IDX_CMD) begin
                                w_cand_nxt = w_data;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    assign bus.trigger_out   = r_trig;
    assign bus.pkt_valid     = r_valid;
    assign bus.crc_error     = r_crc_err;
    assign bus.framing_error = r_frm_err;
    assign bus.locked        = (r_state == ST_LOCKED);
    assign bus.cmd_byte      = r_cmd_byte;

endmodule

// File: tb/tb_psc_trigger_receiver.sv
// Directed bench for psc_trigger_receiver: packets are driven serially, expected pulses are queued and
// popped by an independent monitor whenever the receiver raises any pulse output.
module tb_psc_trigger_receiver;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [3:0] K_TRIG  = 4'b1100;
    localparam logic [3:0] K_VALID = 4'b0100;
    localparam logic [3:0] K_CRC   = 4'b0010;
    localparam logic [3:0] K_FRM   = 4'b0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   bit_t = 100;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_act;

    psc_trigger_receiver_if bus();

    psc_trigger_receiver #(
        .CLKS_PER_BIT(5),
        .PKT_BYTES   (16),
        .SYNC_BYTE   (8'hA5),
        .TRIG_CMD    (8'h54),
        .LOS_BITS    (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Bit-serial CRC-8 (poly 0x07, init 0) over {A5, cmd, 13 x 00}; cmd 0x54 gives 0xA4 by hand.
    function automatic logic [7:0] crc_of(input logic [7:0] cmd);
        logic [7:0] c;
        logic [7:0] d;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 15; i++) begin
            d = (i == 0) ? SYNC : (i == 1) ? cmd : 8'h00;
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ d[b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic send_bit(input logic b);
        bus.psc_input = b;
        #(bit_t);
    endtask

    task automatic idle(input logic v, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(v);
    endtask

    task automatic send_word(input logic [1:0] fr, input logic [7:0] d);
        logic [9:0] w;
        w = {fr, d};
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] crc_flip, input int bad_idx);
        logic [7:0] crc;
        logic [7:0] d;
        logic [1:0] fr;
        crc = crc_of(cmd) ^ crc_flip;
        for (int i = 0; i < 16; i++) begin
            d  = (i == 0) ? SYNC : (i == 1) ? cmd : (i == 15) ? crc : 8'h00;
            fr = (i == bad_idx) ? 2'b11 : 2'b10;
            send_word(fr, d);
        end
    endtask

    task automatic expect_ev(input logic [3:0] kind, input logic [7:0] cmd);
        exp_q.push_back({kind, cmd});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_trigger_out"},   32'(bus.trigger_out),   0);
        chk({tag, "_pkt_valid"},     32'(bus.pkt_valid),     0);
        chk({tag, "_crc_error"},     32'(bus.crc_error),     0);
        chk({tag, "_framing_error"}, 32'(bus.framing_error), 0);
        chk({tag, "_locked"},        32'(bus.locked),        0);
        chk({tag, "_cmd_byte"},      32'(bus.cmd_byte),      0);
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.trigger_out || bus.pkt_valid || bus.crc_error || bus.framing_error)) begin
            mon_act = {bus.trigger_out, bus.pkt_valid, bus.crc_error, bus.framing_error, bus.cmd_byte};
            if (exp_q.size() == 0) chk("unexpected_pulse", 32'(mon_act), 0);
            else                   chk("pulse_event", 32'(mon_act), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        bus.psc_input = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #3;
        idle(1'b1, 5);

        // Trigger, non-trigger, corrupted CRC, then a good packet, all back-to-back.
        expect_ev(K_TRIG, 8'h54);   send_pkt(8'h54, 8'h00, -1);
        expect_ev(K_VALID, 8'h11);  send_pkt(8'h11, 8'h00, -1);
        expect_ev(K_CRC, 8'h11);    send_pkt(8'h22, 8'h01, -1);
        expect_ev(K_TRIG, 8'h54);   send_pkt(8'h54, 8'h00, -1);
        chk("locked_after_packets", 32'(bus.locked), 1);

        // Framing bits 11 in byte 5 drop the packet; relock on the next SYNC.
        expect_ev(K_FRM, 8'h54);    send_pkt(8'h54, 8'h00, 5);
        chk("locked_after_frame_fault", 32'(bus.locked), 0);
        idle(1'b1, 3);
        expect_ev(K_TRIG, 8'h54);   send_pkt(8'h54, 8'h00, -1);
        chk("relocked", 32'(bus.locked), 1);

        // Line held low while locked: exactly one framing_error.
        expect_ev(K_FRM, 8'h54);    idle(1'b0, 25);
        chk("locked_after_los", 32'(bus.locked), 0);

        // Reset in the middle of a packet: outputs clear at once, the packet is lost.
        idle(1'b1, 3);
        expect_ev(K_VALID, 8'h11);  send_pkt(8'h11, 8'h00, -1);
        fork
            send_pkt(8'h54, 8'h00, -1);
            begin
                #(6 * 10 * bit_t + 5);
                reset = 1'b1;
                #1;
                check_all_zero("midpkt_reset");
                #40;
                reset = 1'b0;
            end
        join
        idle(1'b1, 3);
        expect_ev(K_VALID, 8'h33);  send_pkt(8'h33, 8'h00, -1);
        expect_ev(K_FRM, 8'h33);    idle(1'b0, 25);

        // 100 back-to-back trigger packets at 4.8 clocks per bit, asynchronous to clk.
        bit_t = 96;
        idle(1'b1, 3);
        for (int p = 0; p < 100; p++) begin
            expect_ev(K_TRIG, 8'h54);
            send_pkt(8'h54, 8'h00, -1);
        end
        expect_ev(K_FRM, 8'h54);    idle(1'b0, 25);
        bit_t = 100;

        repeat (50) @(posedge clk);
        #3;
        chk("events_outstanding", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
